encoder8x3_queued: RTL and testbench
====================================

Name: encoder8x3_queued

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's 3x8 one-hot decoder.
- Watches 8 event lines, latches each rising edge as a pending request, and emits one 3-bit binary (octal digit) code per request over a valid/ready handshake.
- Sits between raw one-hot sources (keypad, status strobes) and downstream logic that consumes octal codes.

Parameters:
- LINES, 8, number of event lines; only 8 is supported.
- CODE_W, 3, output code width; must equal clog2(LINES).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- D  input  LINES  event lines, synchronous to clk; a 0->1 transition on D[i] is one request for code i
- out_ready  input  1  consumer accepts Q when high with out_valid
- ovf_clr  input  1  synchronous clear of ovf
- Q  output  CODE_W  encoded index, registered
- out_valid  output  1  Q holds a valid code
- pending  output  LINES  registered outstanding requests, excluding the one currently on Q
- ovf  output  1  sticky: a request was lost

Behaviour:
- Reset values (async, rst=1): Q=0, out_valid=0, pending=0, ovf=0, state=IDLE, edge-history register d_q=8'hFF.
  - Because d_q resets to 8'hFF, lines already high when reset releases do not generate requests.
- Edge detect: new_evt = D & ~d_q; d_q <= D every cycle.
- Pending update: pending <= (pending & ~sel_clr) | new_evt.
  - sel_clr is the one-hot bit loaded into Q this cycle.
  - A new edge on the same line in the same cycle keeps the bit set. This is not an overflow.
- Selection (fixed priority): highest set index of pending wins; for example, pending=8'b0010_0100 selects 5. This matches 74148 ordering.
- FSM states: IDLE, HOLD.
  - IDLE: if pending!=0, load Q=sel, clear that bit, set out_valid=1, go to HOLD. Otherwise stay in IDLE with out_valid=0.
  - HOLD, out_ready=0: Q and out_valid are held stable; selection is frozen.
  - HOLD, out_ready=1 and pending!=0: load the next code in the same cycle; out_valid stays 1. Throughput is 1 code/cycle.
  - HOLD, out_ready=1 and pending=0: out_valid=0, go to IDLE.
- Latency: edge present on D in cycle n -> pending bit set at edge n+1 -> Q/out_valid at edge n+2, when idle.
- Overflow: new_evt[i] while pending[i]=1 and i is not being cleared this cycle -> ovf<=1.
  - The request is merged, not queued twice.
  - An edge on the code currently held in Q (already removed from pending) is a fresh request, not an overflow.
  - ovf_clr=1 clears ovf. If a new overflow occurs in the same cycle, set wins.
- Multiple simultaneous edges: all are latched; they are emitted in priority order over successive handshakes.
- Reset mid-operation: all state is lost immediately, including pending requests and any held Q. No partial output.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined: add a CODE_W-bit pointer last_sel (reset 0), updated on every load.
  - Search starts at index last_sel-1 and moves downward, wrapping from 0 to 7.
  - Starvation-free: with all 8 bits pending, codes 7,6,...,0 are emitted, then the cycle repeats.
- Undefined: fixed highest-index priority as above. No pointer logic is synthesized.

Decomposition:
- Package encoder_pkg:
  - constants LINES=8, CODE_W=3
  - state enum {IDLE, HOLD}
  - typedef line_vec_t = logic[LINES-1:0]
  - typedef code_t = logic[CODE_W-1:0]
- Sub-module prio_enc8: purely combinational.
  - Inputs: line_vec_t req, code_t start.
  - Outputs: found, code_t idx, line_vec_t onehot.
  - Fixed-priority builds tie start to 7. The top level holds all registers and the FSM.

Test Plan:
- Single event: after reset, pulse D=8'h04 for 1 cycle with out_ready=1 -> out_valid high 2 cycles later with Q=3'd2 for exactly 1 cycle; pending=0; ovf=0.
- Burst priority: D goes 8'h00->8'hA1 in one cycle, out_ready=1 -> Q sequence 7,5,0 on consecutive cycles with out_valid continuous; pending steps 8'h21, 8'h01, 8'h00.
- Backpressure: burst 8'h03 with out_ready=0 for 5 cycles -> Q=1 held stable and pending=8'h01 throughout; raise out_ready -> Q=0 next, then out_valid falls.
- Overflow: with out_ready=0 and Q=3'd7 held, pulse D[2] twice (separated by a low cycle) -> ovf=1, only one code 2 emitted. Pulse ovf_clr -> ovf=0. Pulse D[7] again -> new code 7 later, ovf stays 0.
- Reset: D held 8'hFF through reset release -> no requests. Assert rst mid-burst -> outputs go to reset values immediately, with no further codes after release.
- With ENC_ROUND_ROBIN_EN: hold out_ready=1 and re-pulse D=8'hFF each time pending empties -> Q order 7..0 repeating, with no index skipped or repeated within a round.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg -- shared types and constants for the queued 8-to-3 encoder.
//
// Contents:
//   LINES, CODE_W : number of event lines (8) and output code width (3)
//   state_t       : handshake FSM states (IDLE, HOLD)
//   line_vec_t    : one bit per event line
//   code_t        : binary (octal digit) line index
package encoder_pkg;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [LINES-1:0]  line_vec_t;
  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/encoder8x3_queued_prio_enc8.sv
// prio_enc8 -- combinational circular priority encoder over 8 request lines.
//
// The search starts at index 'start' and walks downward, wrapping from 0 to 7.
// Tying start to 7 gives plain highest-index-wins (74148 ordering).
//
// Ports:
//   req    in   request vector
//   start  in   first index examined
//   found  out  at least one request bit is set
//   idx    out  index of the winning request (0 when none)
//   onehot out  winning request as a one-hot vector (0 when none)
module prio_enc8
  import encoder_pkg::*;
(
  input  line_vec_t req,
  input  code_t     start,
  output logic      found,
  output code_t     idx,
  output line_vec_t onehot
);

  code_t cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand   = '0;
    for (int k = 0; k < LINES; k++) begin
      // Modulo-8 subtraction provides the wrap from 0 back to 7.
      cand = start - code_t'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    onehot = found ? (line_vec_t'(1) << idx) : '0;
  end

endmodule

// File: rtl/encoder8x3_queued.sv
// encoder8x3_queued -- sequential 8-to-3 encoder with request queueing.
//
// Each rising edge on D[i] latches a pending request for code i. Requests are
// emitted one per handshake on Q/out_valid/out_ready, highest index first.
// A repeated edge on a line whose request is still pending is merged and
// flags the sticky ovf bit.
//
// Optional build macro ENC_ROUND_ROBIN_EN: replaces fixed priority with a
// rotating search that starts just below the last emitted code, so no line
// can starve the others.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   D          in   event lines (synchronous to clk)
//   out_ready  in   consumer accepts Q when high together with out_valid
//   ovf_clr    in   synchronous clear of ovf (a same-cycle overflow wins)
//   Q          out  registered code being offered
//   out_valid  out  Q holds a valid code
//   pending    out  outstanding requests, excluding the one on Q
//   ovf        out  sticky lost-request flag
//
// LINES must be 8 and CODE_W must be 3; other values are not supported.
module encoder8x3_queued #(
  parameter int LINES  = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINES-1:0]  D,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic [CODE_W-1:0] Q,
  output logic              out_valid,
  output logic [LINES-1:0]  pending,
  output logic              ovf
);

  import encoder_pkg::*;

  state_t    state, state_nxt;
  line_vec_t d_q;
  line_vec_t new_evt;
  line_vec_t sel_clr;
  line_vec_t sel_onehot;
  code_t     sel_idx;
  code_t     start;
  logic      sel_found;
  logic      load;
  logic      drop;
  logic      ovf_set;

  // Edge detect / selection
  assign new_evt = D & ~d_q;
  assign sel_clr = load ? sel_onehot : '0;
  // An edge on the code held in Q is a fresh request because that bit was
  // already removed from pending; only a still-pending, uncleared bit overflows.
  assign ovf_set = |(new_evt & pending & ~sel_clr);

`ifdef ENC_ROUND_ROBIN_EN
  code_t last_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_sel <= '0;
    else if (load)
      last_sel <= sel_idx;
  end

  assign start = last_sel - code_t'(1);
`else
  assign start = code_t'(LINES - 1);
`endif

  prio_enc8 u_prio (
    .req    (pending),
    .start  (start),
    .found  (sel_found),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = HOLD;
      HOLD:    if (out_ready && !sel_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: load a new code into Q, or retire the current one
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: load = sel_found;
      HOLD: begin
        if (out_ready) begin
          load = sel_found;
          drop = !sel_found;
        end
      end
      default: begin
        load = 1'b0;
        drop = 1'b0;
      end
    endcase
  end

  // Registered request queue and output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // All ones so lines already high at reset release do not count as edges.
      d_q       <= '1;
      pending   <= '0;
      Q         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      d_q     <= D;
      pending <= (pending & ~sel_clr) | new_evt;
      if (load) begin
        Q         <= sel_idx;
        out_valid <= 1'b1;
      end else if (drop) begin
        out_valid <= 1'b0;
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder8x3_queued.sv
// Testbench for encoder8x3_queued: directed scenarios plus a code scoreboard.
// Expected codes are queued when stimulus is applied and popped by a monitor
// whenever the DUT completes a handshake.
module tb_encoder8x3_queued;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       out_ready;
  logic       ovf_clr;
  logic [2:0] Q;
  logic       out_valid;
  logic [7:0] pending;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];

  encoder8x3_queued #(.LINES(8), .CODE_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .Q         (Q),
    .out_valid (out_valid),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: sampled on the falling edge, i.e. the values that the
  // next rising edge will see.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected: got code %0d, expected no output", Q);
      end else begin
        logic [2:0] exp_code;
        exp_code = sb.pop_front();
        if (Q !== exp_code) begin
          errors = errors + 1;
          $display("FAIL sb_code: got %0d, expected %0d", Q, exp_code);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic vld_exp, input logic [2:0] q_exp,
                         input logic [7:0] pend_exp);
    checks = checks + 1;
    if (out_valid !== vld_exp || (vld_exp && Q !== q_exp) || pending !== pend_exp) begin
      errors = errors + 1;
      $display("FAIL %s: got valid=%b Q=%0d pending=%h, expected valid=%b Q=%0d pending=%h",
               name, out_valid, Q, pending, vld_exp, q_exp, pend_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; D = 8'hFF; out_ready = 1'b1; ovf_clr = 1'b0;
    step(); step();
    checks = checks + 1;
    if (Q !== 3'd0 || out_valid !== 1'b0 || pending !== 8'h00 || ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_values: got Q=%0d valid=%b pending=%h ovf=%b, expected 0 0 00 0",
               Q, out_valid, pending, ovf);
    end
    rst = 1'b0;
    // D stays high across reset release: no edges, no requests.
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("reset_high_lines", 1'b0, 3'd0, 8'h00);
    end
    D = 8'h00;
    step(); step();
    chk_out("reset_lines_fall", 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    sb.push_back(3'd2);
    D = 8'h04;
    step();
    D = 8'h00;
    chk_out("single_pending", 1'b0, 3'd0, 8'h04);
    step();
    chk_out("single_valid", 1'b1, 3'd2, 8'h00);
    step();
    chk_out("single_drop", 1'b0, 3'd0, 8'h00);
    checks = checks + 1;
    if (ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL single_ovf: got %b, expected 0", ovf);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    sb.push_back(3'd7); sb.push_back(3'd5); sb.push_back(3'd0);
    D = 8'hA1;
    step();
    D = 8'h00;
    chk_out("burst_latch", 1'b0, 3'd0, 8'hA1);
    step();
    chk_out("burst_q7", 1'b1, 3'd7, 8'h21);
    step();
    chk_out("burst_q5", 1'b1, 3'd5, 8'h01);
    step();
    chk_out("burst_q0", 1'b1, 3'd0, 8'h00);
    step();
    chk_out("burst_end", 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sb.push_back(3'd1); sb.push_back(3'd0);
    D = 8'h03;
    step();
    D = 8'h00;
    step();
    chk_out("bp_first", 1'b1, 3'd1, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("bp_hold", 1'b1, 3'd1, 8'h01);
    end
    out_ready = 1'b1;
    step();
    chk_out("bp_next", 1'b1, 3'd0, 8'h00);
    step();
    chk_out("bp_end", 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    sb.push_back(3'd7);
    D = 8'h80; step(); D = 8'h00; step();
    chk_out("ovf_hold7", 1'b1, 3'd7, 8'h00);
    D = 8'h04; step(); D = 8'h00; step();
    checks = checks + 1;
    if (ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL ovf_first_edge: got %b, expected 0", ovf);
    end
    D = 8'h04; step(); D = 8'h00;
    checks = checks + 1;
    if (ovf !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL ovf_set: got %b, expected 1", ovf);
    end
    chk_out("ovf_merged", 1'b1, 3'd7, 8'h04);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks = checks + 1;
    if (ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL ovf_clear: got %b, expected 0", ovf);
    end
    // Edge on the code currently held in Q: a fresh request, no overflow.
    D = 8'h80; step(); D = 8'h00; step();
    checks = checks + 1;
    if (ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL ovf_held_code: got %b, expected 0", ovf);
    end
    chk_out("ovf_requeue", 1'b1, 3'd7, 8'h84);
    sb.push_back(3'd7); sb.push_back(3'd2);
    out_ready = 1'b1;
    step();
    chk_out("ovf_q7_again", 1'b1, 3'd7, 8'h04);
    step();
    chk_out("ovf_q2_once", 1'b1, 3'd2, 8'h00);
    step();
    chk_out("ovf_end", 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    sb.push_back(3'd7); sb.push_back(3'd6); sb.push_back(3'd5);
    D = 8'hE0; step(); D = 8'h00; step();
    chk_out("rstmid_first", 1'b1, 3'd7, 8'h60);
    // Asynchronous: no clock edge between assert and check.
    rst = 1'b1;
    #1;
    sb.delete();
    checks = checks + 1;
    if (Q !== 3'd0 || out_valid !== 1'b0 || pending !== 8'h00 || ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rstmid_async: got Q=%0d valid=%b pending=%h ovf=%b, expected 0 0 00 0",
               Q, out_valid, pending, ovf);
    end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("rstmid_quiet", 1'b0, 3'd0, 8'h00);
    end
  endtask

`ifdef ENC_ROUND_ROBIN_EN
  task automatic test_round_robin();
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 7; c >= 0; c--) sb.push_back(3'(c));
      D = 8'hFF; step(); D = 8'h00;
      for (int c = 7; c >= 0; c--) begin
        step();
        checks = checks + 1;
        if (out_valid !== 1'b1 || Q !== 3'(c)) begin
          errors = errors + 1;
          $display("FAIL rr_order: round %0d got valid=%b Q=%0d, expected valid=1 Q=%0d",
                   r, out_valid, Q, c);
        end
      end
      step();
      chk_out("rr_round_end", 1'b0, 3'd0, 8'h00);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; D = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
`ifdef ENC_ROUND_ROBIN_EN
    test_round_robin();
`endif
    step(); step();
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_leftover: got %0d codes never emitted, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
